// File: rtl/bp_pkg.sv
// Shared definitions for the branch-resolution slice.
//   PC_W          : program-counter width
//   pred_entry_t  : one in-flight prediction (instruction PC + predicted next PC)
//   state_t       : resolve FSM states
package bp_pkg;

  localparam int PC_W = 48;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_pc;
  } pred_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage : bp_pkg

// File: rtl/br_resolve_pred_fifo.sv
// In-order queue of fetch-side predictions awaiting resolution.
//   clk, n_reset : clock, asynchronous active-low reset
//   push, din    : append an entry (ignored when full unless popping too)
//   pop          : discard the head entry (ignored when empty)
//   clear        : drop every entry; wins over push and pop
//   head         : oldest entry (undefined when count == 0)
//   count        : occupancy, 0..DEPTH
module pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       push,
  input  pred_entry_t                din,
  input  logic                       pop,
  input  logic                       clear,
  output pred_entry_t                head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  pred_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic              push_ok;

  // A pop frees a slot in the same cycle, so a push while full is legal then.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL_CNT) || pop_ok);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; count and pointers alone define validity,
  // and leaving the array unreset lets it map onto plain RAM/flops cheaply.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= din;
  end

  // Pointers are power-of-two wide, so +1 wraps modulo DEPTH on its own.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : pred_fifo

// File: rtl/br_resolve.sv
// Execute-side branch resolution: compares each resolved next-PC against
// the oldest queued prediction and produces predictor/fetch feedback.
//   clk, n_reset           : clock, asynchronous active-low reset
//   enq_valid/pc/pred_pc   : fetch pushes a prediction
//   enq_ready              : room in queue and not flushing
//   res_valid/pc/next_pc   : execute resolves the oldest instruction
//   mispred, hit           : one-cycle result pulses (registered)
//   flush                  : held FLUSH_LEN cycles after a mispredict
//   correct_pc, index_pc   : redirect target / offending PC, held until next mispredict
//   count                  : queue occupancy
//   sync_err               : sticky, resolution did not line up with the queue head
module br_resolve
  import bp_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int FLUSH_LEN = 2
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       enq_valid,
  input  logic [47:0]                enq_pc,
  input  logic [47:0]                enq_pred_pc,
  output logic                       enq_ready,
  input  logic                       res_valid,
  input  logic [47:0]                res_pc,
  input  logic [47:0]                res_next_pc,
  output logic                       mispred,
  output logic                       hit,
  output logic                       flush,
  output logic [47:0]                correct_pc,
  output logic [47:0]                index_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       sync_err
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int FCNT_W = $clog2(FLUSH_LEN + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_LEN - 1);

  state_t            state, state_next;
  logic [FCNT_W-1:0] fcnt, fcnt_next;

  pred_entry_t head;
  pred_entry_t din;
  logic        do_res;
  logic        q_empty;
  logic        head_match;
  logic        hit_c;
  logic        mis_c;
  logic        err_c;
  logic        push;

  assign din.pc      = enq_pc;
  assign din.pred_pc = enq_pred_pc;

  assign enq_ready = (count != FULL_CNT) && (state == RUN);
  assign flush     = (state == FLUSH);

  // Resolution decode. Results arriving while flushing are wrong-path.
  always_comb begin
    do_res     = res_valid && (state == RUN);
    q_empty    = (count == '0);
    head_match = (head.pc == res_pc);
    hit_c      = do_res && !q_empty && head_match && (res_next_pc == head.pred_pc);
    // A PC mismatch is also redirected: the queue no longer reflects reality.
    mis_c      = do_res && !q_empty && !hit_c;
    err_c      = do_res && (q_empty || !head_match);
    // Enqueue while full is still taken when the head pops this cycle.
    push       = enq_valid && (state == RUN) && ((count != FULL_CNT) || hit_c);
  end

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .din     (din),
    .pop     (hit_c),
    .clear   (mis_c),
    .head    (head),
    .count   (count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      RUN: begin
        if (mis_c) begin
          state_next = FLUSH;
          fcnt_next  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (fcnt == '0) state_next = RUN;
        else            fcnt_next  = fcnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mispred    <= 1'b0;
      hit        <= 1'b0;
      correct_pc <= '0;
      index_pc   <= '0;
      sync_err   <= 1'b0;
    end else begin
      mispred <= mis_c;
      hit     <= hit_c;
      if (err_c) sync_err <= 1'b1;
      if (mis_c) begin
        correct_pc <= res_next_pc;
        // On a genuine mispredict head.pc equals res_pc; on a sync error
        // the resolved PC is the one to report, so res_pc covers both.
        index_pc   <= res_pc;
      end
    end
  end

endmodule : br_resolve

// File: tb/tb_br_resolve.sv
module tb_br_resolve;

  logic        clk;
  logic        n_reset;
  logic        enq_valid;
  logic [47:0] enq_pc;
  logic [47:0] enq_pred_pc;
  logic        enq_ready;
  logic        res_valid;
  logic [47:0] res_pc;
  logic [47:0] res_next_pc;
  logic        mispred;
  logic        hit;
  logic        flush;
  logic [47:0] correct_pc;
  logic [47:0] index_pc;
  logic [3:0]  count;
  logic        sync_err;

  int n_cmp = 0;
  int n_bad = 0;

  br_resolve #(.DEPTH(8), .FLUSH_LEN(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .enq_valid   (enq_valid),
    .enq_pc      (enq_pc),
    .enq_pred_pc (enq_pred_pc),
    .enq_ready   (enq_ready),
    .res_valid   (res_valid),
    .res_pc      (res_pc),
    .res_next_pc (res_next_pc),
    .mispred     (mispred),
    .hit         (hit),
    .flush       (flush),
    .correct_pc  (correct_pc),
    .index_pc    (index_pc),
    .count       (count),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one clock cycle of stimulus starting at a negedge; return at the
  // next negedge, when the registered results of that edge are visible.
  task automatic cycle(input logic ev, input logic [47:0] epc, input logic [47:0] epred,
                       input logic rv, input logic [47:0] rpc, input logic [47:0] rnext);
    enq_valid   = ev;
    enq_pc      = epc;
    enq_pred_pc = epred;
    res_valid   = rv;
    res_pc      = rpc;
    res_next_pc = rnext;
    @(negedge clk);
    enq_valid = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 48'h0, 48'h0, 1'b0, 48'h0, 48'h0);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 4'd0)   begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if ({mispred, hit, flush, sync_err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {mispred, hit, flush, sync_err}); end
    n_cmp++; if (correct_pc !== 48'h0 || index_pc !== 48'h0) begin n_bad++; $display("FAIL reset_pcs got %h/%h want 0/0", correct_pc, index_pc); end
    n_cmp++; if (enq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", enq_ready); end
  endtask

  task automatic test_hit();
    cycle(1'b1, 48'h1000, 48'h1004, 1'b0, 48'h0, 48'h0);
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL hit_count_pre got %0d want 1", count); end
    cycle(1'b0, 48'h0, 48'h0, 1'b1, 48'h1000, 48'h1004);
    n_cmp++; if (hit !== 1'b1 || mispred !== 1'b0) begin n_bad++; $display("FAIL hit_pulse got hit=%b mis=%b want 1/0", hit, mispred); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL hit_count_post got %0d want 0", count); end
    idle();
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL hit_one_cycle got %b want 0", hit); end
  endtask

  task automatic test_mispredict();
    cycle(1'b1, 48'h1000, 48'h1004, 1'b0, 48'h0, 48'h0);
    cycle(1'b1, 48'h1004, 48'h1008, 1'b0, 48'h0, 48'h0);
    cycle(1'b1, 48'h1008, 48'h100C, 1'b0, 48'h0, 48'h0);
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL mis_count_pre got %0d want 3", count); end
    cycle(1'b0, 48'h0, 48'h0, 1'b1, 48'h1000, 48'h2000);
    n_cmp++; if (mispred !== 1'b1 || hit !== 1'b0) begin n_bad++; $display("FAIL mis_pulse got mis=%b hit=%b want 1/0", mispred, hit); end
    n_cmp++; if (index_pc !== 48'h1000 || correct_pc !== 48'h2000) begin n_bad++; $display("FAIL mis_pcs got %h/%h want 1000/2000", index_pc, correct_pc); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL mis_count got %0d want 0", count); end
    n_cmp++; if (flush !== 1'b1 || enq_ready !== 1'b0) begin n_bad++; $display("FAIL mis_flush1 got flush=%b rdy=%b want 1/0", flush, enq_ready); end
    // Wrong-path traffic during flush: both must be ignored.
    cycle(1'b1, 48'h7000, 48'h7004, 1'b1, 48'h7000, 48'h7004);
    n_cmp++; if (flush !== 1'b1 || mispred !== 1'b0 || hit !== 1'b0) begin n_bad++; $display("FAIL mis_flush2 got flush=%b mis=%b hit=%b want 1/0/0", flush, mispred, hit); end
    n_cmp++; if (count !== 4'd0 || sync_err !== 1'b0) begin n_bad++; $display("FAIL mis_ignore got count=%0d serr=%b want 0/0", count, sync_err); end
    idle();
    n_cmp++; if (flush !== 1'b0 || enq_ready !== 1'b1) begin n_bad++; $display("FAIL mis_flush_end got flush=%b rdy=%b want 0/1", flush, enq_ready); end
    n_cmp++; if (correct_pc !== 48'h2000 || index_pc !== 48'h1000) begin n_bad++; $display("FAIL mis_hold got %h/%h want 2000/1000", correct_pc, index_pc); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 48'h2000 + 48'(16 * i), 48'h2004 + 48'(16 * i), 1'b0, 48'h0, 48'h0);
    end
    n_cmp++; if (count !== 4'd8 || enq_ready !== 1'b0) begin n_bad++; $display("FAIL full_state got count=%0d rdy=%b want 8/0", count, enq_ready); end
    cycle(1'b1, 48'h9990, 48'h9994, 1'b0, 48'h0, 48'h0);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_drop got %0d want 8", count); end
    // Pop head while pushing a new tail into the freed slot.
    cycle(1'b1, 48'h2080, 48'h2084, 1'b1, 48'h2000, 48'h2004);
    n_cmp++; if (hit !== 1'b1 || count !== 4'd8) begin n_bad++; $display("FAIL full_pushpop got hit=%b count=%0d want 1/8", hit, count); end
    // Drain in order across the pointer wrap: 0x2010..0x2070 then 0x2080.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 48'h0, 48'h0, 1'b1, 48'h2000 + 48'(16 * i), 48'h2004 + 48'(16 * i));
      n_cmp++;
      if (hit !== 1'b1 || mispred !== 1'b0 || count !== 4'(8 - i)) begin
        n_bad++;
        $display("FAIL drain_%0d got hit=%b mis=%b count=%0d want 1/0/%0d", i, hit, mispred, count, 8 - i);
      end
    end
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL drain_sync got %b want 0", sync_err); end
  endtask

  task automatic test_enq_on_mispred();
    cycle(1'b1, 48'h4000, 48'h4004, 1'b0, 48'h0, 48'h0);
    cycle(1'b1, 48'h3000, 48'h3004, 1'b1, 48'h4000, 48'h5000);
    n_cmp++; if (mispred !== 1'b1 || count !== 4'd0) begin n_bad++; $display("FAIL enqmis_pulse got mis=%b count=%0d want 1/0", mispred, count); end
    idle();
    idle();
    n_cmp++; if (flush !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL enqmis_after got flush=%b count=%0d want 0/0", flush, count); end
  endtask

  task automatic test_sync_err();
    cycle(1'b0, 48'h0, 48'h0, 1'b1, 48'h1234, 48'h1238);
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL serr_empty got %b want 1", sync_err); end
    n_cmp++; if ({mispred, hit, flush} !== 3'b000) begin n_bad++; $display("FAIL serr_empty_pulses got %b want 000", {mispred, hit, flush}); end
    idle();
    n_cmp++; if (sync_err !== 1'b1) begin n_bad++; $display("FAIL serr_sticky got %b want 1", sync_err); end
    do_reset();
    n_cmp++; if (sync_err !== 1'b0) begin n_bad++; $display("FAIL serr_reset got %b want 0", sync_err); end
    cycle(1'b1, 48'h4000, 48'h4004, 1'b0, 48'h0, 48'h0);
    cycle(1'b0, 48'h0, 48'h0, 1'b1, 48'h5000, 48'h5004);
    n_cmp++; if (sync_err !== 1'b1 || mispred !== 1'b1 || flush !== 1'b1) begin n_bad++; $display("FAIL serr_pc got serr=%b mis=%b flush=%b want 1/1/1", sync_err, mispred, flush); end
    n_cmp++; if (index_pc !== 48'h5000 || correct_pc !== 48'h5004 || count !== 4'd0) begin n_bad++; $display("FAIL serr_pcs got %h/%h count=%0d want 5000/5004/0", index_pc, correct_pc, count); end
  endtask

  // Entered in the first FLUSH cycle left by test_sync_err.
  task automatic test_reset_in_flush();
    cycle(1'b1, 48'h6000, 48'h6004, 1'b0, 48'h0, 48'h0);
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL rif_pre got flush=%b want 1", flush); end
    #2;
    n_reset = 1'b0;
    #1;
    n_cmp++; if (flush !== 1'b0 || mispred !== 1'b0 || count !== 4'd0) begin n_bad++; $display("FAIL rif_async got flush=%b mis=%b count=%0d want 0/0/0", flush, mispred, count); end
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (enq_ready !== 1'b1 || flush !== 1'b0) begin n_bad++; $display("FAIL rif_release got rdy=%b flush=%b want 1/0", enq_ready, flush); end
  endtask

  initial begin
    n_reset     = 1'b0;
    enq_valid   = 1'b0;
    enq_pc      = '0;
    enq_pred_pc = '0;
    res_valid   = 1'b0;
    res_pc      = '0;
    res_next_pc = '0;
    @(negedge clk);
    test_reset();
    test_hit();
    test_mispredict();
    test_full_wrap();
    test_enq_on_mispred();
    test_sync_err();
    test_reset_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_br_resolve
